// File: rtl/mod_updown_counter.sv
// Parametrised up/down counter with modulus, parallel load, clear, wrap or
// saturate at the terminal value, and a combinational cascade terminal count.
module mod_updown_counter #(
  parameter int unsigned WIDTH     = 8,
  parameter logic [31:0] MAX_COUNT = 32'd255,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrapped,
  output logic             saturated
);

  localparam logic [WIDTH-1:0] MAX_VAL = MAX_COUNT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

  function automatic logic at_terminal(input logic [WIDTH-1:0] v, input logic dir_up);
    return dir_up ? (v == MAX_VAL) : (v == '0);
  endfunction

  logic             terminal;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] count_nxt;
  logic             wrapped_nxt;
  logic             saturated_nxt;

  assign terminal     = at_terminal(count, up);
  assign load_clamped = clamp_load(load_value);
  assign tc           = enable & terminal;

  // Next-state selection: clear > load > enable > hold
  always_comb begin
    count_nxt     = count;
    wrapped_nxt   = 1'b0;
    saturated_nxt = saturated;
    if (clear) begin
      count_nxt     = '0;
      saturated_nxt = 1'b0;
    end else if (load) begin
      count_nxt     = load_clamped;
      saturated_nxt = SATURATE & at_terminal(load_clamped, up);
    end else if (enable) begin
      if (!terminal) begin
        count_nxt     = up ? (count + ONE) : (count - ONE);
        saturated_nxt = 1'b0;
      end else if (SATURATE) begin
        saturated_nxt = 1'b1;
      end else begin
        count_nxt   = up ? '0 : MAX_VAL;
        wrapped_nxt = 1'b1;
      end
    end
  end

  // Count register stage
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count     <= '0;
      wrapped   <= 1'b0;
      saturated <= 1'b0;
    end else begin
      count     <= count_nxt;
      wrapped   <= wrapped_nxt;
      saturated <= saturated_nxt;
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: five instances (8-bit wrap, mod-10 wrap,
// mod-10 saturate, two-stage 4-bit cascade) against an arithmetic model.
module tb_mod_updown_counter;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_value = 8'd0;
  logic       enable = 1'b0;
  logic       up = 1'b1;

  logic [7:0] c8;
  logic [3:0] c9, cs, clo, chi;
  logic       t8, t9, ts, tlo, thi;
  logic       w8, w9, ws, wlo, whi;
  logic       s8, s9, ss, slo, shi;

  always #5 clock = ~clock;

  mod_updown_counter #(.WIDTH(8), .MAX_COUNT(255), .SATURATE(1'b0)) u_d8 (
    .clock(clock), .resetn(resetn), .clear(clear), .load(load),
    .load_value(load_value), .enable(enable), .up(up),
    .count(c8), .tc(t8), .wrapped(w8), .saturated(s8));

  mod_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b0)) u_d9 (
    .clock(clock), .resetn(resetn), .clear(clear), .load(load),
    .load_value(load_value[3:0]), .enable(enable), .up(up),
    .count(c9), .tc(t9), .wrapped(w9), .saturated(s9));

  mod_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b1)) u_d9s (
    .clock(clock), .resetn(resetn), .clear(clear), .load(load),
    .load_value(load_value[3:0]), .enable(enable), .up(up),
    .count(cs), .tc(ts), .wrapped(ws), .saturated(ss));

  mod_updown_counter #(.WIDTH(4), .MAX_COUNT(15), .SATURATE(1'b0)) u_lo (
    .clock(clock), .resetn(resetn), .clear(clear), .load(load),
    .load_value(load_value[3:0]), .enable(enable), .up(up),
    .count(clo), .tc(tlo), .wrapped(wlo), .saturated(slo));

  mod_updown_counter #(.WIDTH(4), .MAX_COUNT(15), .SATURATE(1'b0)) u_hi (
    .clock(clock), .resetn(resetn), .clear(clear), .load(load),
    .load_value(load_value[7:4]), .enable(tlo), .up(up),
    .count(chi), .tc(thi), .wrapped(whi), .saturated(shi));

  // Reference model: one entry per instance (0=d8, 1=d9, 2=d9s, 3=lo, 4=hi)
  int mx[5]   = '{255, 9, 9, 15, 15};
  int mask[5] = '{255, 15, 15, 15, 15};
  int lsh[5]  = '{0, 0, 0, 0, 4};
  bit sm[5]   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  int m_cnt[5];
  bit m_wr[5];
  bit m_sat[5];

  int n_cmp = 0;
  int n_err = 0;

  function automatic bit m_term(int k);
    return up ? (m_cnt[k] == mx[k]) : (m_cnt[k] == 0);
  endfunction

  function automatic bit m_tc(int k);
    bit e;
    e = (k == 4) ? (enable && m_term(3)) : enable;
    return e && m_term(k);
  endfunction

  function automatic void m_step(int k, bit e);
    int nxt;
    if (clear) begin
      m_cnt[k] = 0; m_wr[k] = 0; m_sat[k] = 0;
    end else if (load) begin
      nxt = (int'(load_value) >> lsh[k]) & mask[k];
      if (nxt > mx[k]) nxt = mx[k];
      m_cnt[k] = nxt;
      m_wr[k]  = 0;
      m_sat[k] = sm[k] && (up ? (nxt == mx[k]) : (nxt == 0));
    end else if (e) begin
      nxt = up ? m_cnt[k] + 1 : m_cnt[k] - 1;
      if (nxt >= 0 && nxt <= mx[k]) begin
        m_cnt[k] = nxt; m_wr[k] = 0; m_sat[k] = 0;
      end else if (sm[k]) begin
        m_wr[k] = 0; m_sat[k] = 1;
      end else begin
        m_cnt[k] = (nxt + mx[k] + 1) % (mx[k] + 1);
        m_wr[k]  = 1;
      end
    end else begin
      m_wr[k] = 0;
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int a_cnt[5];
    bit a_tc[5], a_wr[5], a_sat[5];
    a_cnt = '{int'(c8), int'(c9), int'(cs), int'(clo), int'(chi)};
    a_tc  = '{t8, t9, ts, tlo, thi};
    a_wr  = '{w8, w9, ws, wlo, whi};
    a_sat = '{s8, s9, ss, slo, shi};
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("model count[%0d]", k), a_cnt[k], m_cnt[k]);
      chk($sformatf("model tc[%0d]", k), int'(a_tc[k]), int'(m_tc(k)));
      chk($sformatf("model wrapped[%0d]", k), int'(a_wr[k]), int'(m_wr[k]));
      chk($sformatf("model saturated[%0d]", k), int'(a_sat[k]), int'(m_sat[k]));
    end
  endtask

  // One clock edge with current inputs; called 1 time unit after a posedge
  task automatic tick();
    bit e_hi;
    e_hi = m_tc(3);
    for (int k = 0; k < 5; k++) m_step(k, (k == 4) ? e_hi : enable);
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    for (int k = 0; k < 5; k++) begin
      m_cnt[k] = 0; m_wr[k] = 0; m_sat[k] = 0;
    end
    #2;
    check_all();
    #2;
    resetn = 1'b1;
    #1;
  endtask

  task automatic set_in(input bit clr, input bit ld, input logic [7:0] lv,
                        input bit en, input bit u);
    clear = clr; load = ld; load_value = lv; enable = en; up = u;
  endtask

  typedef struct {
    bit         clr;
    bit         ld;
    logic [7:0] lv;
    bit         en;
    bit         u;
    int         ecnt;
    bit         etc;
    bit         ewr;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #100000000;
    $display("FAIL watchdog: simulation did not finish, n_err %0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 1'b1, 8'd250, 1'b0, 1'b1, 250, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 8'd0,   1'b1, 1'b1, 251, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 8'd255, 1'b1, 1'b1, 255, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 8'd0,   1'b1, 1'b1, 0,   1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 255, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 254, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 8'd5,   1'b1, 1'b0, 0,   1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 8'd5,   1'b1, 1'b1, 5,   1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 8'd0,   1'b0, 1'b1, 5,   1'b0, 1'b0};

    #6;
    do_reset();
    chk("reset count", int'(c8), 0);
    chk("reset wrapped", int'(w8), 0);
    chk("reset saturated", int'(ss), 0);

    // Table-driven vectors on the 8-bit wrap instance
    for (int i = 0; i < 9; i++) begin
      set_in(tbl[i].clr, tbl[i].ld, tbl[i].lv, tbl[i].en, tbl[i].u);
      tick();
      chk($sformatf("tbl[%0d] count", i), int'(c8), tbl[i].ecnt);
      chk($sformatf("tbl[%0d] tc", i), int'(t8), int'(tbl[i].etc));
      chk($sformatf("tbl[%0d] wrapped", i), int'(w8), int'(tbl[i].ewr));
    end

    // Full 8-bit up sweep with wrap
    do_reset();
    set_in(1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
    for (int i = 0; i < 256; i++) tick();
    chk("sweep count after 256", int'(c8), 0);
    chk("sweep wrapped after 256", int'(w8), 1);

    // Mod-10 counting down from reset
    do_reset();
    set_in(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    tick();
    chk("mod10 down first count", int'(c9), 9);
    chk("mod10 down first wrapped", int'(w9), 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 8) chk("mod10 down tc at 0", int'(t9), 1);
    end
    chk("mod10 down after 10", int'(c9), 9);

    // Saturating mod-10: clamped load, hold, release on direction change
    do_reset();
    set_in(1'b0, 1'b1, 8'd12, 1'b0, 1'b1);
    tick();
    chk("sat load clamp count", int'(cs), 9);
    chk("sat load saturated", int'(ss), 1);
    set_in(1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    chk("sat hold count", int'(cs), 9);
    chk("sat hold saturated", int'(ss), 1);
    chk("sat hold wrapped", int'(ws), 0);
    up = 1'b0;
    tick();
    chk("sat release count", int'(cs), 8);
    chk("sat release saturated", int'(ss), 0);

    // Priority and asynchronous reset between edges
    set_in(1'b1, 1'b1, 8'd5, 1'b1, 1'b1);
    tick();
    chk("prio clear count", int'(c8), 0);
    set_in(1'b0, 1'b1, 8'd5, 1'b0, 1'b1);
    tick();
    chk("prio load count", int'(c8), 5);
    load = 1'b0;
    do_reset();
    chk("async reset count", int'(c8), 0);

    // Two-stage cascade: 300 enabled up edges
    do_reset();
    set_in(1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
    for (int i = 0; i < 300; i++) tick();
    chk("cascade value", int'({chi, clo}), 300 % 256);
    chk("cascade d8 value", int'(c8), 300 % 256);

    // Enable low mid-count
    set_in(1'b0, 1'b1, 8'd7, 1'b0, 1'b1);
    tick();
    load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle count", int'(c8), 7);
      chk("idle tc", int'(t8), 0);
      chk("idle wrapped", int'(w8), 0);
    end

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      set_in(($urandom % 25) == 0, ($urandom % 8) == 0, 8'($urandom % 256),
             ($urandom % 4) != 0, ($urandom % 3) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
- Parametrised synchronous up/down counter; successor to the team's fixed 8-bit T-flip-flop enable counter.
- Adds configurable width and modulus, count direction, parallel load, synchronous clear, wrap or saturate mode, and a cascade terminal-count output.
- Used as the general counter primitive for timers, prescalers and display scan logic. Instances chain through en/tc to build wider counters.

Parameters:
WIDTH, 8, counter register width in bits (legal range 2..32)
MAX_COUNT, 255, highest count value; 1 <= MAX_COUNT <= 2^WIDTH-1; count range is 0..MAX_COUNT
SATURATE, 0, 0 = wrap at the terminal value; 1 = hold at the terminal value

Ports:
clock  input  1  rising-edge clock
resetn  input  1  asynchronous active-low reset
clear  input  1  synchronous clear to 0
load  input  1  synchronous parallel load
load_value  input  WIDTH  value taken on load
enable  input  1  count enable (cascade input)
up  input  1  1 = count up, 0 = count down
count  output  WIDTH  registered count value
tc  output  1  combinational terminal count: enable & (up ? count==MAX_COUNT : count==0)
wrapped  output  1  registered one-cycle pulse: a wrap occurred on the previous edge
saturated  output  1  registered level: the count is held at its terminal value (SATURATE=1 only)

Behaviour:
- Reset (resetn=0, asynchronous, any time): count=0, wrapped=0, saturated=0. tc follows its equation with count=0.
- Release of reset is synchronous to clock. The first count update happens on the first rising edge with resetn=1.
- Per-edge priority: clear > load > enable > hold.
- clear=1: count<=0, wrapped<=0, saturated<=0. enable, load and up are ignored.
- load=1 (clear=0): count<=min(load_value, MAX_COUNT). A load_value above MAX_COUNT is clamped. wrapped<=0. saturated<=1 only if SATURATE=1 and the loaded value equals the terminal value for the current up.
- enable=1, up=1, count<MAX_COUNT: count<=count+1.
- enable=1, up=0, count>0: count<=count-1.
- Terminal reached (enable=1 and at the terminal value for the current direction):
  - SATURATE=0: count wraps. Up goes MAX_COUNT->0; down goes 0->MAX_COUNT. wrapped<=1 for exactly one cycle.
  - SATURATE=1: count holds, wrapped stays 0, saturated<=1.
- saturated clears on the first edge where the count moves away from the terminal value, e.g. after a direction change with enable=1.
- enable=0 with no clear or load: count holds, wrapped<=0, saturated holds.
- The up input may change on any cycle and takes effect on the next edge. No glitch filtering.
- Arithmetic is unsigned, WIDTH bits. Values above MAX_COUNT are never produced internally.
- Cascading: connect the lower stage's tc to the upper stage's enable. Both stages share clock, resetn and up. tc is purely combinational; no path from tc back into the same instance.
- Latency: count updates 1 cycle after the qualifying edge. tc updates in the same cycle as count or enable.

Test Plan:
- WIDTH=8, MAX_COUNT=255, SATURATE=0: reset, then enable=1 up=1 for 256 edges -> count 0..255 then 0; tc=1 only while count=255; wrapped=1 for the one cycle after the 255->0 edge.
- MAX_COUNT=9, up=0 from reset -> the first enabled edge gives count=9 with wrapped pulse; 10 further edges return count to 9; tc=1 at count=0.
- MAX_COUNT=9, SATURATE=1: load_value=12 -> count=9 (clamped), saturated=1. Counting up holds at 9. Set up=0 -> next edge count=8, saturated=0.
- Priority: clear=1, load=1, load_value=5, enable=1 on the same edge -> count=0. Next edge load=1 only -> count=5. Assert resetn=0 between edges -> count=0 immediately, with no clock edge.
- Cascade two WIDTH=4, MAX_COUNT=15 instances (low.tc -> high.enable): 300 enabled up edges -> {high,low}=300 mod 256=44. High increments only on the edges where low wraps.
- enable=0 for 20 edges mid-count at count=7 -> count stays 7, tc=0, wrapped=0 throughout.
